// File: rtl/hms_time_keeper_pkg.sv
// hms_time_keeper_pkg: shared mode encodings, field limits and field widths
package hms_time_keeper_pkg;
    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    typedef enum logic [1:0] {
        MODE_RUN      = 2'd0,
        MODE_SET_SEC  = 2'd1,
        MODE_SET_MIN  = 2'd2,
        MODE_SET_HOUR = 2'd3
    } mode_t;
endpackage

// File: rtl/hms_time_keeper_btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability-count debouncer and registered press pulse
module btn_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level,
    output logic o_press
);
    localparam int CNT_W = $clog2(DEB_CYCLES + 1);
    logic [1:0]       sync;
    logic [CNT_W-1:0] cnt;
    logic             level_d;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync    <= '0;
            cnt     <= '0;
            o_level <= 1'b0;
            level_d <= 1'b0;
            o_press <= 1'b0;
        end else begin
            sync    <= {sync[0], i_raw};
            level_d <= o_level;
            o_press <= o_level & ~level_d;
            // the DEB_CYCLES-th consecutive differing sample flips the level
            if (sync[1] == o_level)
                cnt <= '0;
            else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
                cnt     <= '0;
                o_level <= ~o_level;
            end else
                cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/hms_time_keeper.sv
// hms_time_keeper: 1 Hz time-of-day counter with debounced mode/inc buttons for setting fields
module hms_time_keeper
    import hms_time_keeper_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int DEB_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_btn_mode,
    input  logic              i_btn_inc,
    output logic [SEC_W-1:0]  o_sec,
    output logic [MIN_W-1:0]  o_min,
    output logic [HOUR_W-1:0] o_hour,
    output logic [1:0]        o_mode,
    output logic              o_tick
);
    localparam int DIV_W = $clog2(CLK_HZ);
    logic [DIV_W-1:0]  div;
    logic              tick, mode_p, inc_p, run_tick, set_inc, set_done;
    logic              mode_level_unused, inc_level_unused;
    logic [SEC_W-1:0]  sec_inc, sec_n;
    logic [MIN_W-1:0]  min_inc, min_n;
    logic [HOUR_W-1:0] hour_inc, hour_n;
    mode_t             state, state_n;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_mode (
        .clk(clk), .rst(rst), .i_raw(i_btn_mode), .o_level(mode_level_unused), .o_press(mode_p)
    );
    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .i_raw(i_btn_inc), .o_level(inc_level_unused), .o_press(inc_p)
    );

    assign tick     = div == DIV_W'(CLK_HZ - 1);
    assign set_done = mode_p && state == MODE_SET_HOUR;
    assign run_tick = tick && state == MODE_RUN;
    // a mode press in the same cycle swallows the inc press
    assign set_inc  = inc_p && !mode_p && state != MODE_RUN;
    assign sec_inc  = (o_sec == SEC_MAX) ? '0 : o_sec + 6'd1;
    assign min_inc  = (o_min == MIN_MAX) ? '0 : o_min + 6'd1;
    assign hour_inc = (o_hour == HOUR_MAX) ? '0 : o_hour + 5'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= MODE_RUN;
        else
            state <= state_n;
    end

    always_comb state_n = mode_p ? mode_t'(state + 2'd1) : state;

    always_comb o_mode = state;

    always_comb begin
        sec_n  = (run_tick || (set_inc && state == MODE_SET_SEC)) ? sec_inc : o_sec;
        min_n  = ((run_tick && o_sec == SEC_MAX) || (set_inc && state == MODE_SET_MIN)) ? min_inc : o_min;
        hour_n = ((run_tick && o_sec == SEC_MAX && o_min == MIN_MAX) ||
                  (set_inc && state == MODE_SET_HOUR)) ? hour_inc : o_hour;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div    <= '0;
            o_tick <= 1'b0;
            o_sec  <= '0;
            o_min  <= '0;
            o_hour <= '0;
        end else begin
            div    <= (tick || set_done) ? '0 : div + DIV_W'(1);
            o_tick <= tick;
            o_sec  <= sec_n;
            o_min  <= min_n;
            o_hour <= hour_n;
        end
    end
endmodule

// File: doc/hms_time_keeper.md
# hms_time_keeper

Time-of-day core that feeds the two-digit split / seven-segment / six-digit multiplexed display path. It keeps hours, minutes and seconds from a single-clock 1 Hz tick enable; no derived clocks are used. Two raw push-buttons go through synchronisers and debouncers into a mode FSM, which lets the user stop the clock and set each field. Outputs are binary field values plus mode, which downstream digit-split and display blocks consume.

## Interface
- CLK_HZ, 50000000: clk cycles per second tick; minimum 2.
- DEB_CYCLES, 500000: consecutive stable synchronised samples required to accept a button level change; minimum 1.
- clk  in  1  system clock (50 MHz nominal).
- rst  in  1  reset, asynchronous, active-high.
- i_btn_mode  in  1  raw mode button, asynchronous, active-high.
- i_btn_inc  in  1  raw increment button, asynchronous, active-high.
- o_sec  out  6  seconds, 0..59.
- o_min  out  6  minutes, 0..59.
- o_hour  out  5  hours, 0..23.
- o_mode  out  2  current mode: 0 RUN, 1 SET_SEC, 2 SET_MIN, 3 SET_HOUR.
- o_tick  out  1  one-cycle pulse per second tick (also in set modes).

## Operation
- Reset forces: o_sec, o_min and o_hour to 0; o_mode to RUN; o_tick to 0; tick divider to 0; synchronisers and debounced levels to 0; debounce counters to 0.
- Tick divider:
  - Counts 0..CLK_HZ-1 and wraps.
  - The wrap cycle is the tick event.
  - The divider runs in all modes.
  - The divider is cleared to 0 on the SET_HOUR -> RUN transition, so the first second after setting is full length.
- Button path, per button:
  - 2-flop synchroniser.
  - Stability counter: counts consecutive cycles in which the synchronised value differs from the debounced level.
  - Counter clears whenever the values are equal.
  - When the counter reaches DEB_CYCLES, the debounced level toggles and the counter clears.
  - A press pulse is generated on a debounced 0->1 transition only. Release generates no pulse. Holding the button generates no repeat.
- Mode FSM:
  - RUN -> SET_SEC -> SET_MIN -> SET_HOUR -> RUN, advancing on each mode press pulse.
  - No other transitions.
- RUN:
  - Each tick increments sec.
  - sec 59 -> 0 with carry into min.
  - min 59 -> 0 with carry into hour.
  - hour 23 -> 0.
  - 23:59:59 + tick = 00:00:00.
  - Inc presses are ignored.
- SET_x modes:
  - Ticks do not change any field; time is frozen.
  - An inc press increments only the selected field.
  - The field wraps (sec/min 59 -> 0, hour 23 -> 0) with no carry into other fields.
- Simultaneous mode and inc pulses in the same cycle: mode wins; inc is dropped; the field is unchanged.
- Simultaneous tick and mode pulse while in RUN: the tick increment is applied and the FSM moves to SET_SEC in the same edge.
- Reset asserted mid-operation, including mid-debounce: everything returns to reset values immediately. A button still held when rst deasserts is accepted as a press once it has been stable DEB_CYCLES.

## Timing
- All state is updated on the clk rising edge; all outputs are registered.
- Tick:
  - o_tick is high for exactly one cycle, beginning the cycle after the divider holds CLK_HZ-1.
  - The updated field values appear in that same cycle.
  - Tick period is exactly CLK_HZ cycles.
- Button latency:
  - A raw level held steady from edge N produces a registered press pulse visible from edge N+DEB_CYCLES+2, for one cycle.
  - The affected field or o_mode updates at the following edge, N+DEB_CYCLES+3.
- Glitches shorter than DEB_CYCLES synchronised cycles are rejected entirely.

## Structure
- Shared package holds:
  - mode encodings MODE_RUN=2'd0, MODE_SET_SEC=2'd1, MODE_SET_MIN=2'd2, MODE_SET_HOUR=2'd3;
  - constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23;
  - field widths 6/6/5.
- One sub-module, btn_debounce (parameter DEB_CYCLES; ports clk, rst, i_raw, o_level, o_press), instantiated twice.
- Divider, FSM and field counters are in the top module.

## Test plan
Bench parameters are CLK_HZ=10, DEB_CYCLES=4.
- Reset then free-run 600 cycles:
  - o_tick pulses every 10 cycles;
  - after 60 ticks, o_min=1 and o_sec=0;
  - o_mode=0 throughout.
- Preload via set modes to 23:59:58, then return to RUN:
  - 2 ticks later all fields read 0;
  - the first tick arrives 10 cycles after the mode update.
- Mode press ×1 then 3 inc presses:
  - o_mode=1;
  - o_sec increases by 3 with no min change;
  - from sec=58, 3 presses give 1 and o_min is unchanged;
  - ticks during SET_SEC change nothing.
- Inc glitch of 3 cycles in SET_MIN: no change. Held press of 4+ cycles: exactly one increment, at raw edge +7 cycles.
- Mode and inc raw edges aligned in SET_HOUR: o_mode returns to 0 and o_hour is unchanged.
- Assert rst mid-debounce and mid-count with fields at 12:34:56: all outputs are 0 in the next cycle (asynchronous). After release, counting restarts from 00:00:00.
